// File: rtl/fetch_pipe_ctrl.sv
// Fetch-side pipeline control: PC register, IF/ID register, stall/flush handling,
// ID/EX bubble request, saturating perf counters and a sticky stall watchdog.
module fetch_pipe_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INST  = XLEN'(32'h0000_0013),
  parameter int unsigned     MAX_STALL = 1,
  parameter int unsigned     CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             insert_nop,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  if_id_inst,
  output logic [XLEN-1:0]  if_id_pc,
  output logic             if_id_valid,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_err
);

  // Wide enough to hold MAX_STALL+1, the first value that trips the watchdog.
  localparam int unsigned RunW = $clog2(MAX_STALL + 2);

  typedef enum logic [1:0] {
    ActAdvance,
    ActStall,
    ActFlush
  } action_e;

  action_e action;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  inst_q, inst_d;
  logic [XLEN-1:0]  ipc_q, ipc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [RunW-1:0]  run_len_q, run_len_d;
  logic [RunW-1:0]  run_len_inc;
  logic             err_q, err_d;

  always_comb begin
    if (branch_taken) begin
      action = ActFlush;
    end else if (insert_nop) begin
      action = ActStall;
    end else begin
      action = ActAdvance;
    end
  end

  assign run_len_inc = (run_len_q == '1) ? run_len_q : run_len_q + RunW'(1);

  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    ipc_d       = ipc_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    run_len_d   = run_len_q;
    err_d       = err_q;

    unique case (action)
      ActFlush: begin
        // Redirect target is forced word-aligned.
        pc_d      = {branch_target[XLEN-1:2], 2'b00};
        inst_d    = NOP_INST;
        ipc_d     = pc_q;
        valid_d   = 1'b0;
        run_len_d = '0;
        if (flush_cnt_q != '1) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      ActStall: begin
        run_len_d = run_len_inc;
        if (32'(run_len_inc) > MAX_STALL) begin
          err_d = 1'b1;
        end
        if (stall_cnt_q != '1) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        pc_d      = pc_q + XLEN'(4);
        inst_d    = imem_rdata;
        ipc_d     = pc_q;
        valid_d   = 1'b1;
        run_len_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      ipc_q       <= RESET_PC;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      run_len_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      ipc_q       <= ipc_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      run_len_q   <= run_len_d;
      err_q       <= err_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_id_inst   = inst_q;
  assign if_id_pc     = ipc_q;
  assign if_id_valid  = valid_q;
  assign id_ex_bubble = ~rst & (insert_nop | branch_taken);
  assign stall_count  = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
  assign stall_err    = err_q;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed bench for fetch_pipe_ctrl: vector table plus hand sequences for
// run-length clearing and counter saturation on a narrow-counter instance.
module tb_fetch_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        insert_nop;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        id_ex_bubble;
  logic [31:0] stall_count;
  logic [31:0] flush_count;
  logic        stall_err;

  logic [31:0] s_imem_addr;
  logic [31:0] s_if_id_inst;
  logic [31:0] s_if_id_pc;
  logic        s_if_id_valid;
  logic        s_id_ex_bubble;
  logic [3:0]  s_stall_count;
  logic [3:0]  s_flush_count;
  logic        s_stall_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ROM: word i holds i + 0x100.
  assign imem_rdata = (imem_addr >> 2) + 32'h100;

  fetch_pipe_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .insert_nop   (insert_nop),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_rdata   (imem_rdata),
    .imem_addr    (imem_addr),
    .if_id_inst   (if_id_inst),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid),
    .id_ex_bubble (id_ex_bubble),
    .stall_count  (stall_count),
    .flush_count  (flush_count),
    .stall_err    (stall_err)
  );

  fetch_pipe_ctrl #(
    .MAX_STALL(100),
    .CNT_W    (4)
  ) u_small (
    .clk          (clk),
    .rst          (rst),
    .insert_nop   (insert_nop),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_rdata   (imem_rdata),
    .imem_addr    (s_imem_addr),
    .if_id_inst   (s_if_id_inst),
    .if_id_pc     (s_if_id_pc),
    .if_id_valid  (s_if_id_valid),
    .id_ex_bubble (s_id_ex_bubble),
    .stall_count  (s_stall_count),
    .flush_count  (s_flush_count),
    .stall_err    (s_stall_err)
  );

  typedef struct {
    logic        rst;
    logic        nop;
    logic        br;
    logic [31:0] tgt;
    logic        bubble;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        valid;
    logic [31:0] scnt;
    logic [31:0] fcnt;
    logic        err;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs[NVec];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic n, input logic b, input logic [31:0] t);
    rst           = r;
    insert_nop    = n;
    branch_taken  = b;
    branch_target = t;
  endtask

  // One clock: drive, check comb bubble, clock, settle.
  task automatic cycle(input logic r, input logic n, input logic b, input logic [31:0] t,
                       input int idx, input logic exp_bubble);
    drive(r, n, b, t);
    #1;
    check("id_ex_bubble", idx, 32'(id_ex_bubble), 32'(exp_bubble));
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst  nop  br   tgt            bub  pc             inst           ipc            v    scnt fcnt err
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h80,        1'b0, 32'h0,        32'h13,        32'h0,         1'b0, 0, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        32'h13,        32'h0,         1'b0, 0, 0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4,        32'h100,       32'h0,         1'b1, 0, 0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8,        32'h101,       32'h4,         1'b1, 0, 0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,        32'h101,       32'h4,         1'b1, 1, 0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'hC,        32'h102,       32'h8,         1'b1, 1, 0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h10,       32'h103,       32'hC,         1'b1, 1, 0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h41,        1'b1, 32'h40,       32'h13,        32'h10,        1'b0, 1, 1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h44,       32'h110,       32'h40,        1'b1, 1, 1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'hBAD0,      1'b1, 32'h44,       32'h110,       32'h40,        1'b1, 2, 1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h44,       32'h110,       32'h40,        1'b1, 3, 1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h44,       32'h110,       32'h40,        1'b1, 4, 1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h48,       32'h111,       32'h44,        1'b1, 4, 1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h13,       32'h48,        1'b0, 4, 2, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        32'h4000_00FF, 32'hFFFF_FFFC, 1'b1, 4, 2, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'hDEAD,      1'b0, 32'h4,        32'h100,       32'h0,         1'b1, 4, 2, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        32'h13,        32'h0,         1'b0, 0, 0, 1'b0};

    drive(1'b1, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < NVec; i++) begin
      cycle(vecs[i].rst, vecs[i].nop, vecs[i].br, vecs[i].tgt, i, vecs[i].bubble);
      check("imem_addr",   i, imem_addr,          vecs[i].pc);
      check("if_id_inst",  i, if_id_inst,         vecs[i].inst);
      check("if_id_pc",    i, if_id_pc,           vecs[i].ipc);
      check("if_id_valid", i, 32'(if_id_valid),   32'(vecs[i].valid));
      check("stall_count", i, stall_count,        vecs[i].scnt);
      check("flush_count", i, flush_count,        vecs[i].fcnt);
      check("stall_err",   i, 32'(stall_err),     32'(vecs[i].err));
    end

    // A flush between two single stalls must clear the run length.
    cycle(1'b0, 1'b1, 1'b0, 32'h0,  100, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h20, 101, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0,  102, 1'b1);
    check("runlen_clear_err",   102, 32'(stall_err), 32'd0);
    check("runlen_clear_pc",    102, imem_addr,      32'h20);
    check("runlen_clear_scnt",  102, stall_count,    32'd2);
    check("runlen_clear_fcnt",  102, flush_count,    32'd1);

    // Narrow counter saturates; wide one keeps counting.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 200, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 201 + i, 1'b1);
    end
    check("sat_small_scnt", 300, 32'(s_stall_count), 32'hF);
    check("sat_small_err",  300, 32'(s_stall_err),   32'd0);
    check("sat_wide_scnt",  300, stall_count,        32'd20);
    check("sat_wide_err",   300, 32'(stall_err),     32'd1);
    check("sat_pc_hold",    300, imem_addr,          32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 301, 1'b0);
    check("sat_small_hold", 301, 32'(s_stall_count), 32'hF);
    check("err_sticky",     301, 32'(stall_err),     32'd1);
    check("resume_pc",      301, imem_addr,          32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
